// File: rtl/bus_pkg.sv
// Shared bus definitions: default geometry, lock FSM states and the named
// source indices used by benches and the control unit.
package bus_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_N_SRC = 16;

   typedef enum logic {
      OPEN   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   localparam int R0     = 0;
   localparam int R1     = 1;
   localparam int R2     = 2;
   localparam int R3     = 3;
   localparam int R4     = 4;
   localparam int R5     = 5;
   localparam int R6     = 6;
   localparam int R7     = 7;
   localparam int R8     = 8;
   localparam int R9     = 9;
   localparam int R10    = 10;
   localparam int R11    = 11;
   localparam int R12    = 12;
   localparam int R13    = 13;
   localparam int R14    = 14;
   localparam int R15    = 15;
   localparam int HI     = 16;
   localparam int LO     = 17;
   localparam int ZHI    = 18;
   localparam int ZLO    = 19;
   localparam int PC     = 20;
   localparam int MDR    = 21;
   localparam int INPORT = 22;
   localparam int C_SIGN = 23;

endpackage

// File: rtl/bus_prio_encoder.sv
// Combinational last-writer priority encoder over the bus drive strobes.
module bus_prio_encoder
   import bus_pkg::*;
#(
   parameter int N_SRC = DEF_N_SRC
) (
   input  logic [N_SRC-1:0]         src_out,
   output logic [$clog2(N_SRC)-1:0] win,
   output logic                     any_valid,
   output logic                     multi
);

   localparam int OW = $clog2(N_SRC);

   always_comb begin
      win = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (src_out[i]) win = OW'(i);
      end
   end

   assign any_valid = |src_out;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi     = |(src_out & (src_out - N_SRC'(1)));

endmodule

// File: rtl/bus_mux_arbiter.sv
// Registered source-select bus with conflict detection and a saturating
// conflict counter. Optional owner lock is enabled by defining BUS_LOCK_EN.
module bus_mux_arbiter
   import bus_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N_SRC = DEF_N_SRC,
   parameter int CNT_W = 8
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic [N_SRC*WIDTH-1:0]   src_data,
   input  logic [N_SRC-1:0]         src_out,
   input  logic                     bus_lock,
   output logic [WIDTH-1:0]         bus_out,
   output logic                     bus_valid,
   output logic [$clog2(N_SRC)-1:0] owner,
   output logic                     conflict,
   output logic [CNT_W-1:0]         conflict_cnt
);

   localparam int OW = $clog2(N_SRC);

   logic [N_SRC-1:0] w_req;
   logic [OW-1:0]    w_win;
   logic             w_any;
   logic             w_multi;

   logic [WIDTH-1:0] r_bus;
   logic             r_valid;
   logic [OW-1:0]    r_owner;
   logic             r_conflict;
   logic [CNT_W-1:0] r_cnt;

`ifdef BUS_LOCK_EN
   lock_state_t r_state;
   logic [OW-1:0] r_lock_owner;

   // While held, only the locked owner's strobe reaches the encoder.
   always_comb begin
      w_req = src_out;
      if (r_state == LOCKED && bus_lock) w_req = src_out & (N_SRC'(1) << r_lock_owner);
   end
`else
   logic w_unused_lock;
   assign w_unused_lock = bus_lock;
   assign w_req = src_out;
`endif

   bus_prio_encoder #(
      .N_SRC(N_SRC)
   ) u_enc (
      .src_out  (w_req),
      .win      (w_win),
      .any_valid(w_any),
      .multi    (w_multi)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         r_bus      <= '0;
         r_valid    <= 1'b0;
         r_owner    <= '0;
         r_conflict <= 1'b0;
         r_cnt      <= '0;
`ifdef BUS_LOCK_EN
         r_state      <= OPEN;
         r_lock_owner <= '0;
`endif
      end else begin
         r_valid    <= w_any;
         r_conflict <= w_multi;
         if (w_any) begin
            r_bus   <= src_data[w_win*WIDTH +: WIDTH];
            r_owner <= w_win;
         end
         if (w_multi && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
`ifdef BUS_LOCK_EN
         case (r_state)
            OPEN: begin
               if (bus_lock && w_any) begin
                  r_state      <= LOCKED;
                  r_lock_owner <= w_win;
               end
            end
            LOCKED: begin
               if (!bus_lock) r_state <= OPEN;
            end
            default: r_state <= OPEN;
         endcase
`endif
      end
   end

   assign bus_out      = r_bus;
   assign bus_valid    = r_valid;
   assign owner        = r_owner;
   assign conflict     = r_conflict;
   assign conflict_cnt = r_cnt;

endmodule
